// File: rtl/sargantana_icache_pkg.sv
// Shared definitions for the Sargantana instruction-cache refill slice.
// Cache geometry, the refill FSM state type, the victim pointer type and
// the helpers that build the L2 line address and one-hot way enables.
package sargantana_icache_pkg;

  localparam int ICACHE_N_WAY      = 4;
  localparam int ICACHE_TAG_WIDTH  = 22;
  localparam int ICACHE_IDX_WIDTH  = 6;
  localparam int WAY_WIDHT         = 128;
  localparam int PADDR_SIZE        = 32;
  // Byte offset within a line; refill requests are always line aligned.
  localparam int ICACHE_OFF_WIDTH  = PADDR_SIZE - ICACHE_TAG_WIDTH - ICACHE_IDX_WIDTH;
  localparam int VICTIM_PTR_W      = $clog2(ICACHE_N_WAY);

  typedef logic [VICTIM_PTR_W-1:0] victim_ptr_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DRAIN = 3'd4
  } refill_state_t;

  // Line address sent to L2: {tag, index, zero offset}.
  function automatic logic [PADDR_SIZE-1:0] make_paddr(
    input logic [ICACHE_TAG_WIDTH-1:0] tag,
    input logic [ICACHE_IDX_WIDTH-1:0] idx
  );
    make_paddr = {tag, idx, {ICACHE_OFF_WIDTH{1'b0}}};
  endfunction

  function automatic logic [ICACHE_N_WAY-1:0] way_onehot(input victim_ptr_t way);
    way_onehot      = '0;
    way_onehot[way] = 1'b1;
  endfunction

endpackage

// File: rtl/sargantana_icache_tzc_idx.sv
// Trailing-zero-count index: position of the lowest set bit of in_i.
// Ports:
//   in_i    [ICACHE_N_WAY-1:0]  vector to scan
//   idx_o   [VICTIM_PTR_W-1:0]  index of lowest set bit (0 when empty)
//   empty_o                     no bit of in_i is set
module sargantana_icache_tzc_idx
  import sargantana_icache_pkg::*;
(
  input  logic [ICACHE_N_WAY-1:0] in_i,
  output logic [VICTIM_PTR_W-1:0] idx_o,
  output logic                    empty_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = ICACHE_N_WAY - 1; i >= 0; i--) begin
      if (in_i[i]) begin
        idx_o = VICTIM_PTR_W'(i);
      end
    end
    empty_o = ~|in_i;
  end

endmodule

// File: rtl/sargantana_icache_refill.sv
// Instruction-cache line refill controller.
// Accepts a miss, picks a victim way, requests the line from L2, waits for
// the single-beat response and installs tag, data and valid bit in one
// cycle. A kill aborts the refill; a response still owed by L2 is drained
// and discarded.
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   miss_i/miss_ready_o             miss request handshake (ready = idle)
//   miss_idx_i, miss_tag_i          set index and tag of the missing line
//   way_valid_bits_i                valid bits of the indexed set
//   kill_i                          abort outstanding refill
//   ifill_req_valid_o/_ready_i      line request handshake to L2
//   ifill_req_paddr_o               line address {tag, idx, 0}
//   ifill_resp_valid_i, _data_i     full-line response from L2
//   tag_we_o, data_we_o, valid_set_o one-hot way write enables
//   wr_idx_o, wr_tag_o, wr_data_o   write payload
//   fill_done_o                     one-cycle pulse, line installed
module sargantana_icache_refill
  import sargantana_icache_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        miss_i,
  input  logic [ICACHE_IDX_WIDTH-1:0] miss_idx_i,
  input  logic [ICACHE_TAG_WIDTH-1:0] miss_tag_i,
  input  logic [ICACHE_N_WAY-1:0]     way_valid_bits_i,
  output logic                        miss_ready_o,
  input  logic                        kill_i,
  output logic                        ifill_req_valid_o,
  input  logic                        ifill_req_ready_i,
  output logic [PADDR_SIZE-1:0]       ifill_req_paddr_o,
  input  logic                        ifill_resp_valid_i,
  input  logic [WAY_WIDHT-1:0]        ifill_resp_data_i,
  output logic [ICACHE_N_WAY-1:0]     tag_we_o,
  output logic [ICACHE_N_WAY-1:0]     data_we_o,
  output logic [ICACHE_N_WAY-1:0]     valid_set_o,
  output logic [ICACHE_IDX_WIDTH-1:0] wr_idx_o,
  output logic [ICACHE_TAG_WIDTH-1:0] wr_tag_o,
  output logic [WAY_WIDHT-1:0]        wr_data_o,
  output logic                        fill_done_o
);

  refill_state_t               state_reg, state_next;
  logic [ICACHE_IDX_WIDTH-1:0] idx_reg;
  logic [ICACHE_TAG_WIDTH-1:0] tag_reg;
  logic [WAY_WIDHT-1:0]        data_reg;
  victim_ptr_t                 victim_reg;
  victim_ptr_t                 rr_ptr_reg;
  logic                        used_rr_reg;

  victim_ptr_t first_invalid;
  logic        set_full;
  victim_ptr_t victim_sel;
  logic        miss_accept;
  logic        resp_accept;

  sargantana_icache_tzc_idx u_tzc_idx (
    .in_i    (~way_valid_bits_i),
    .idx_o   (first_invalid),
    .empty_o (set_full)
  );

  // A free way always wins; the round-robin pointer only replaces live lines.
  assign victim_sel  = set_full ? rr_ptr_reg : first_invalid;
  // kill_i alongside a miss in IDLE means the miss is already stale.
  assign miss_accept = (state_reg == IDLE) && miss_i && !kill_i;
  assign resp_accept = (state_reg == WAIT) && ifill_resp_valid_i && !kill_i;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Miss latches, response data latch and round-robin pointer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_reg     <= '0;
      tag_reg     <= '0;
      victim_reg  <= '0;
      used_rr_reg <= 1'b0;
      data_reg    <= '0;
      rr_ptr_reg  <= '0;
    end else begin
      if (miss_accept) begin
        idx_reg     <= miss_idx_i;
        tag_reg     <= miss_tag_i;
        victim_reg  <= victim_sel;
        used_rr_reg <= set_full;
      end
      if (resp_accept) begin
        data_reg <= ifill_resp_data_i;
      end
      // Advance only once a round-robin victim has actually been written.
      if ((state_reg == WRITE) && used_rr_reg) begin
        if (rr_ptr_reg == VICTIM_PTR_W'(ICACHE_N_WAY - 1)) begin
          rr_ptr_reg <= '0;
        end else begin
          rr_ptr_reg <= rr_ptr_reg + 1'b1;
        end
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (miss_accept) state_next = REQ;
      end
      REQ: begin
        // A handshake in the kill cycle still obliges L2 to answer.
        if (kill_i) begin
          state_next = ifill_req_ready_i ? DRAIN : IDLE;
        end else if (ifill_req_ready_i) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (ifill_resp_valid_i) begin
          state_next = kill_i ? IDLE : WRITE;
        end else if (kill_i) begin
          state_next = DRAIN;
        end
      end
      WRITE: begin
        state_next = IDLE;
      end
      DRAIN: begin
        if (ifill_resp_valid_i) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    miss_ready_o      = 1'b0;
    ifill_req_valid_o = 1'b0;
    fill_done_o       = 1'b0;
    tag_we_o          = '0;
    data_we_o         = '0;
    valid_set_o       = '0;
    case (state_reg)
      IDLE: miss_ready_o = 1'b1;
      REQ:  ifill_req_valid_o = 1'b1;
      WRITE: begin
        tag_we_o    = way_onehot(victim_reg);
        data_we_o   = way_onehot(victim_reg);
        valid_set_o = way_onehot(victim_reg);
        fill_done_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign ifill_req_paddr_o = make_paddr(tag_reg, idx_reg);
  assign wr_idx_o          = idx_reg;
  assign wr_tag_o          = tag_reg;
  assign wr_data_o         = data_reg;

endmodule

// File: tb/tb_sargantana_icache_refill.sv
// Randomized self-checking bench for sargantana_icache_refill. A small
// reference model (victim choice and round-robin pointer) predicts every fill.
module tb_sargantana_icache_refill;
  import sargantana_icache_pkg::*;

  logic                        clk_i = 1'b0;
  logic                        rst_i;
  logic                        miss_i;
  logic [ICACHE_IDX_WIDTH-1:0] miss_idx_i;
  logic [ICACHE_TAG_WIDTH-1:0] miss_tag_i;
  logic [ICACHE_N_WAY-1:0]     way_valid_bits_i;
  logic                        miss_ready_o;
  logic                        kill_i;
  logic                        ifill_req_valid_o;
  logic                        ifill_req_ready_i;
  logic [PADDR_SIZE-1:0]       ifill_req_paddr_o;
  logic                        ifill_resp_valid_i;
  logic [WAY_WIDHT-1:0]        ifill_resp_data_i;
  logic [ICACHE_N_WAY-1:0]     tag_we_o;
  logic [ICACHE_N_WAY-1:0]     data_we_o;
  logic [ICACHE_N_WAY-1:0]     valid_set_o;
  logic [ICACHE_IDX_WIDTH-1:0] wr_idx_o;
  logic [ICACHE_TAG_WIDTH-1:0] wr_tag_o;
  logic [WAY_WIDHT-1:0]        wr_data_o;
  logic                        fill_done_o;

  int checks = 0;
  int errors = 0;
  int model_rr = 0;

  always #5 clk_i = ~clk_i;

  sargantana_icache_refill dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .miss_i             (miss_i),
    .miss_idx_i         (miss_idx_i),
    .miss_tag_i         (miss_tag_i),
    .way_valid_bits_i   (way_valid_bits_i),
    .miss_ready_o       (miss_ready_o),
    .kill_i             (kill_i),
    .ifill_req_valid_o  (ifill_req_valid_o),
    .ifill_req_ready_i  (ifill_req_ready_i),
    .ifill_req_paddr_o  (ifill_req_paddr_o),
    .ifill_resp_valid_i (ifill_resp_valid_i),
    .ifill_resp_data_i  (ifill_resp_data_i),
    .tag_we_o           (tag_we_o),
    .data_we_o          (data_we_o),
    .valid_set_o        (valid_set_o),
    .wr_idx_o           (wr_idx_o),
    .wr_tag_o           (wr_tag_o),
    .wr_data_o          (wr_data_o),
    .fill_done_o        (fill_done_o)
  );

  // Reference victim: lowest free way, else the round-robin way.
  function automatic int model_victim(input logic [ICACHE_N_WAY-1:0] valid);
    int v;
    v = -1;
    for (int w = ICACHE_N_WAY - 1; w >= 0; w--) if (!valid[w]) v = w;
    if (v < 0) v = model_rr;
    return v;
  endfunction

  function automatic logic [ICACHE_N_WAY-1:0] model_onehot(input int v);
    logic [ICACHE_N_WAY-1:0] oh;
    oh = '0;
    oh[v] = 1'b1;
    return oh;
  endfunction

  function automatic logic [WAY_WIDHT-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_reset();
    rst_i = 1'b1;
    miss_i = 1'b0; kill_i = 1'b0;
    ifill_req_ready_i = 1'b0; ifill_resp_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    model_rr = 0;
    @(negedge clk_i);
  endtask

  // Issue a miss at a negedge; it is accepted on the following posedge.
  task automatic issue_miss(input logic [ICACHE_IDX_WIDTH-1:0] idx,
                            input logic [ICACHE_TAG_WIDTH-1:0] tag,
                            input logic [ICACHE_N_WAY-1:0] valid);
    int n;
    n = 0;
    @(negedge clk_i);
    while (!miss_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    miss_i = 1'b1; miss_idx_i = idx; miss_tag_i = tag; way_valid_bits_i = valid;
    @(posedge clk_i);
    #1;
    miss_i = 1'b0;
    way_valid_bits_i = ICACHE_N_WAY'($urandom);
  endtask

  // Drives one complete refill and reports what the DUT did.
  // stray counts cycles with write enables or request valid where none belongs;
  // paddr_bad counts request cycles whose address differed from the miss.
  task automatic run_fill(input logic [ICACHE_IDX_WIDTH-1:0] idx,
                          input logic [ICACHE_TAG_WIDTH-1:0] tag,
                          input logic [ICACHE_N_WAY-1:0] valid,
                          input int ready_delay, input int resp_delay,
                          input logic [WAY_WIDHT-1:0] data,
                          output int lat,
                          output logic [ICACHE_N_WAY-1:0] o_tag_we,
                          output logic [ICACHE_N_WAY-1:0] o_data_we,
                          output logic [ICACHE_N_WAY-1:0] o_valid_set,
                          output logic [ICACHE_IDX_WIDTH-1:0] o_idx,
                          output logic [ICACHE_TAG_WIDTH-1:0] o_tag,
                          output logic [WAY_WIDHT-1:0] o_data,
                          output int stray, output int paddr_bad);
    int phase, cnt;
    logic [PADDR_SIZE-1:0] exp_paddr;
    exp_paddr = {tag, idx, {ICACHE_OFF_WIDTH{1'b0}}};
    lat = -1; stray = 0; paddr_bad = 0; phase = 0; cnt = 0;
    o_tag_we = '0; o_data_we = '0; o_valid_set = '0; o_idx = '0; o_tag = '0; o_data = '0;
    issue_miss(idx, tag, valid);
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk_i);
      if (fill_done_o) begin
        lat = k;
        o_tag_we = tag_we_o; o_data_we = data_we_o; o_valid_set = valid_set_o;
        o_idx = wr_idx_o; o_tag = wr_tag_o; o_data = wr_data_o;
        ifill_resp_valid_i = 1'b0; ifill_req_ready_i = 1'b0;
        break;
      end
      if ((tag_we_o | data_we_o | valid_set_o) != '0) stray++;
      if (phase == 0) begin
        if (!ifill_req_valid_o) stray++;
        if (ifill_req_paddr_o !== exp_paddr) paddr_bad++;
        if (cnt >= ready_delay) begin
          ifill_req_ready_i = 1'b1; phase = 1; cnt = 0;
        end else begin
          ifill_req_ready_i = 1'b0; cnt++;
        end
      end else if (phase == 1) begin
        ifill_req_ready_i = 1'b0;
        if (ifill_req_valid_o) stray++;
        if (cnt >= resp_delay) begin
          ifill_resp_valid_i = 1'b1; ifill_resp_data_i = data; phase = 2;
        end else begin
          ifill_resp_valid_i = 1'b0; ifill_resp_data_i = rand_line(); cnt++;
        end
      end else begin
        ifill_resp_valid_i = 1'b0;
      end
    end
    ifill_resp_valid_i = 1'b0; ifill_req_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    miss_i = 1'b0; kill_i = 1'b0; miss_idx_i = '0; miss_tag_i = '0;
    way_valid_bits_i = '0; ifill_req_ready_i = 1'b0; ifill_resp_valid_i = 1'b0;
    ifill_resp_data_i = '0;
    repeat (2) @(negedge clk_i);
    checks++;
    if (miss_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_miss_ready got %b expected 1", miss_ready_o);
    end
    checks++;
    if ({ifill_req_valid_o, fill_done_o, tag_we_o, data_we_o, valid_set_o} !== '0) begin
      errors++; $display("FAIL reset_ctrl_outputs got %b/%b/%b/%b/%b expected all 0",
                         ifill_req_valid_o, fill_done_o, tag_we_o, data_we_o, valid_set_o);
    end
    checks++;
    if ({ifill_req_paddr_o, wr_idx_o, wr_tag_o, wr_data_o} !== '0) begin
      errors++; $display("FAIL reset_payload got paddr %h idx %h tag %h expected 0",
                         ifill_req_paddr_o, wr_idx_o, wr_tag_o);
    end
    rst_i = 1'b0;
    model_rr = 0;
    @(negedge clk_i);
  endtask

  task automatic test_directed_fill();
    int lat, stray, pbad;
    logic [ICACHE_N_WAY-1:0] twe, dwe, vset;
    logic [ICACHE_IDX_WIDTH-1:0] oidx;
    logic [ICACHE_TAG_WIDTH-1:0] otag;
    logic [WAY_WIDHT-1:0] odata, line;
    do_reset();
    line = rand_line();
    run_fill(6'd5, 22'h1A, 4'b0101, 0, 0, line, lat, twe, dwe, vset, oidx, otag, odata, stray, pbad);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL directed_latency got %0d expected 3", lat); end
    checks++;
    if (twe !== 4'b0010 || dwe !== 4'b0010 || vset !== 4'b0010) begin
      errors++; $display("FAIL directed_we got %b/%b/%b expected 0010", twe, dwe, vset);
    end
    checks++;
    if (oidx !== 6'd5 || otag !== 22'h1A) begin
      errors++; $display("FAIL directed_payload got idx %0d tag %h expected 5 1a", oidx, otag);
    end
    checks++;
    if (odata !== line) begin errors++; $display("FAIL directed_data got %h expected %h", odata, line); end
    checks++;
    if (stray !== 0 || pbad !== 0) begin
      errors++; $display("FAIL directed_protocol got stray %0d paddr_bad %0d expected 0 0", stray, pbad);
    end
    @(negedge clk_i);
    checks++;
    if (fill_done_o !== 1'b0 || tag_we_o !== '0) begin
      errors++; $display("FAIL directed_pulse_width got done %b we %b expected 0", fill_done_o, tag_we_o);
    end
  endtask

  task automatic test_round_robin();
    int lat, stray, pbad;
    int exp_way [5] = '{0, 1, 2, 3, 0};
    logic [ICACHE_N_WAY-1:0] twe, dwe, vset, exp_oh;
    logic [ICACHE_IDX_WIDTH-1:0] oidx;
    logic [ICACHE_TAG_WIDTH-1:0] otag;
    logic [WAY_WIDHT-1:0] odata;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_fill(ICACHE_IDX_WIDTH'($urandom), ICACHE_TAG_WIDTH'($urandom), 4'b1111, 0, 0,
               rand_line(), lat, twe, dwe, vset, oidx, otag, odata, stray, pbad);
      exp_oh = model_onehot(exp_way[i]);
      checks++;
      if (twe !== exp_oh || dwe !== exp_oh || vset !== exp_oh) begin
        errors++; $display("FAIL rr_victim_%0d got %b expected %b", i, twe, exp_oh);
      end
      model_rr = (model_rr + 1) % ICACHE_N_WAY;
    end
  endtask

  task automatic test_ready_stall();
    int lat, stray, pbad;
    logic [ICACHE_N_WAY-1:0] twe, dwe, vset;
    logic [ICACHE_IDX_WIDTH-1:0] oidx;
    logic [ICACHE_TAG_WIDTH-1:0] otag;
    logic [WAY_WIDHT-1:0] odata;
    run_fill(6'd33, 22'h2BEEF, 4'b0111, 5, 0, rand_line(),
             lat, twe, dwe, vset, oidx, otag, odata, stray, pbad);
    checks++;
    if (pbad !== 0) begin errors++; $display("FAIL stall_paddr_stable got %0d bad cycles expected 0", pbad); end
    checks++;
    if (stray !== 0) begin errors++; $display("FAIL stall_no_write got %0d stray cycles expected 0", stray); end
    checks++;
    if (lat !== 8 || twe !== 4'b1000) begin
      errors++; $display("FAIL stall_fill got lat %0d we %b expected 8 1000", lat, twe);
    end
  endtask

  task automatic test_kill_wait();
    int bad;
    bad = 0;
    issue_miss(6'd9, 22'h77, 4'b0011);
    @(negedge clk_i); ifill_req_ready_i = 1'b1;           // REQ, handshake
    @(negedge clk_i); ifill_req_ready_i = 1'b0;           // WAIT cycle 1
    @(negedge clk_i); kill_i = 1'b1;                      // WAIT cycle 2
    @(negedge clk_i); kill_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (miss_ready_o || fill_done_o || ((tag_we_o | data_we_o | valid_set_o) != '0)) bad++;
      if (c == 3) begin ifill_resp_valid_i = 1'b1; ifill_resp_data_i = rand_line(); end
      @(negedge clk_i);
    end
    ifill_resp_valid_i = 1'b0;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL kill_wait_drain got %0d bad cycles expected 0", bad); end
    checks++;
    if (miss_ready_o !== 1'b1 || fill_done_o !== 1'b0 || tag_we_o !== '0) begin
      errors++; $display("FAIL kill_wait_after_resp got ready %b done %b we %b expected 1 0 0",
                         miss_ready_o, fill_done_o, tag_we_o);
    end
  endtask

  task automatic test_kill_req();
    // Kill without handshake: back to IDLE at once.
    issue_miss(6'd1, 22'h10, 4'b0000);
    @(negedge clk_i); kill_i = 1'b1; ifill_req_ready_i = 1'b0;
    @(negedge clk_i); kill_i = 1'b0;
    checks++;
    if (miss_ready_o !== 1'b1 || ifill_req_valid_o !== 1'b0) begin
      errors++; $display("FAIL kill_req_idle got ready %b req %b expected 1 0", miss_ready_o, ifill_req_valid_o);
    end
    // Kill with handshake: must drain the owed response.
    issue_miss(6'd2, 22'h20, 4'b0000);
    @(negedge clk_i); kill_i = 1'b1; ifill_req_ready_i = 1'b1;
    @(negedge clk_i); kill_i = 1'b0; ifill_req_ready_i = 1'b0;
    checks++;
    if (miss_ready_o !== 1'b0 || ifill_req_valid_o !== 1'b0) begin
      errors++; $display("FAIL kill_req_drain got ready %b req %b expected 0 0", miss_ready_o, ifill_req_valid_o);
    end
    ifill_resp_valid_i = 1'b1;
    @(negedge clk_i); ifill_resp_valid_i = 1'b0;
    checks++;
    if (miss_ready_o !== 1'b1 || fill_done_o !== 1'b0) begin
      errors++; $display("FAIL kill_req_drain_end got ready %b done %b expected 1 0", miss_ready_o, fill_done_o);
    end
    // Kill coinciding with the response in WAIT: discard, no write.
    issue_miss(6'd3, 22'h30, 4'b0000);
    @(negedge clk_i); ifill_req_ready_i = 1'b1;
    @(negedge clk_i); ifill_req_ready_i = 1'b0; ifill_resp_valid_i = 1'b1; kill_i = 1'b1;
    @(negedge clk_i); ifill_resp_valid_i = 1'b0; kill_i = 1'b0;
    checks++;
    if (miss_ready_o !== 1'b1 || fill_done_o !== 1'b0 || tag_we_o !== '0) begin
      errors++; $display("FAIL kill_wait_with_resp got ready %b done %b we %b expected 1 0 0",
                         miss_ready_o, fill_done_o, tag_we_o);
    end
    // Miss together with kill in IDLE is ignored.
    @(negedge clk_i); miss_i = 1'b1; kill_i = 1'b1; way_valid_bits_i = 4'b0000;
    @(negedge clk_i); miss_i = 1'b0; kill_i = 1'b0;
    checks++;
    if (miss_ready_o !== 1'b1 || ifill_req_valid_o !== 1'b0) begin
      errors++; $display("FAIL idle_miss_kill got ready %b req %b expected 1 0", miss_ready_o, ifill_req_valid_o);
    end
  endtask

  task automatic test_reset_mid_wait();
    int bad;
    bad = 0;
    issue_miss(6'd12, 22'h3FF, 4'b0001);
    @(negedge clk_i); ifill_req_ready_i = 1'b1;
    @(negedge clk_i); ifill_req_ready_i = 1'b0;           // WAIT
    #2 rst_i = 1'b1;
    #1;                                                   // still before the next rising edge
    checks++;
    if (miss_ready_o !== 1'b1 || ifill_req_valid_o !== 1'b0 || wr_idx_o !== '0 ||
        ifill_req_paddr_o !== '0) begin
      errors++; $display("FAIL async_reset got ready %b req %b idx %0d paddr %h expected 1 0 0 0",
                         miss_ready_o, ifill_req_valid_o, wr_idx_o, ifill_req_paddr_o);
    end
    @(negedge clk_i); rst_i = 1'b0; model_rr = 0;
    ifill_resp_valid_i = 1'b1; ifill_resp_data_i = rand_line();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      ifill_resp_valid_i = 1'b0;
      if (fill_done_o || ((tag_we_o | data_we_o | valid_set_o) != '0) || !miss_ready_o) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL late_resp_after_reset got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_random();
    int lat, stray, pbad, v, rdy, rsp;
    logic [ICACHE_N_WAY-1:0] twe, dwe, vset, valid, exp_oh;
    logic [ICACHE_IDX_WIDTH-1:0] oidx, idx;
    logic [ICACHE_TAG_WIDTH-1:0] otag, tag;
    logic [WAY_WIDHT-1:0] odata, line;
    for (int t = 0; t < 40; t++) begin
      idx = ICACHE_IDX_WIDTH'($urandom);
      tag = ICACHE_TAG_WIDTH'($urandom);
      valid = ($urandom_range(0, 1) == 1) ? 4'b1111 : ICACHE_N_WAY'($urandom);
      rdy = $urandom_range(0, 3);
      rsp = $urandom_range(0, 3);
      line = rand_line();
      v = model_victim(valid);
      exp_oh = model_onehot(v);
      run_fill(idx, tag, valid, rdy, rsp, line, lat, twe, dwe, vset, oidx, otag, odata, stray, pbad);
      checks++;
      if (twe !== exp_oh || dwe !== exp_oh || vset !== exp_oh || oidx !== idx || otag !== tag ||
          odata !== line || lat !== 3 + rdy + rsp || stray !== 0 || pbad !== 0) begin
        errors++;
        $display("FAIL random_fill_%0d got we %b/%b/%b idx %0d tag %h lat %0d stray %0d expected we %b idx %0d tag %h lat %0d stray 0",
                 t, twe, dwe, vset, oidx, otag, lat, stray, exp_oh, idx, tag, 3 + rdy + rsp);
      end
      if (valid == 4'b1111) model_rr = (model_rr + 1) % ICACHE_N_WAY;
    end
  endtask

  initial begin
    test_reset();
    test_directed_fill();
    test_round_robin();
    test_ready_stall();
    test_kill_wait();
    test_kill_req();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sargantana_icache_refill.md
SARGANTANA_ICACHE_REFILL -- requirements
Module: sargantana_icache_refill

Interface
REQ-001 No module parameters SHALL exist; ICACHE_N_WAY, ICACHE_TAG_WIDTH, ICACHE_IDX_WIDTH, WAY_WIDHT and PADDR_SIZE SHALL come from sargantana_icache_pkg.
REQ-002 clk_i  in  1  sole clock, all state on rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 miss_i  in  1  refill request from lookup path.
REQ-005 miss_idx_i  in  ICACHE_IDX_WIDTH  set index of missing line.
REQ-006 miss_tag_i  in  ICACHE_TAG_WIDTH  physical tag of missing line.
REQ-007 way_valid_bits_i  in  ICACHE_N_WAY  valid bits of the indexed set, sampled at miss acceptance.
REQ-008 miss_ready_o  out  1  block idle, miss accepted when miss_i & miss_ready_o.
REQ-009 kill_i  in  1  abort outstanding refill (flush/redirect).
REQ-010 ifill_req_valid_o / ifill_req_ready_i  out/in  1/1  line request handshake to L2.
REQ-011 ifill_req_paddr_o  out  PADDR_SIZE  {tag, idx, offset=0}.
REQ-012 ifill_resp_valid_i  in  1  single-beat full-line response; ifill_resp_data_i  in  WAY_WIDHT  line data.
REQ-013 tag_we_o, data_we_o, valid_set_o  out  ICACHE_N_WAY each  one-hot way write enables.
REQ-014 wr_idx_o  out  ICACHE_IDX_WIDTH; wr_tag_o  out  ICACHE_TAG_WIDTH; wr_data_o  out  WAY_WIDHT  write payload.
REQ-015 fill_done_o  out  1  one-cycle pulse, line installed.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT, WRITE, DRAIN.
REQ-017 IDLE: miss_ready_o=1; on miss accepted, latch idx, tag, victim way, go REQ.
REQ-018 Victim SHALL be lowest-numbered way with valid bit 0; if all valid, round-robin pointer way.
REQ-019 Round-robin pointer (clog2(ICACHE_N_WAY) bits) SHALL increment modulo ICACHE_N_WAY only after a WRITE that used it; wrap N_WAY-1 -> 0.
REQ-020 REQ: ifill_req_valid_o=1, address stable until ifill_req_ready_i; on handshake go WAIT.
REQ-021 WAIT: on ifill_resp_valid_i latch data, go WRITE; requests SHALL NOT be issued.
REQ-022 WRITE: for exactly one cycle assert tag_we_o, data_we_o, valid_set_o one-hot at victim, payload from latches, fill_done_o=1; next state IDLE.
REQ-023 Minimum miss-to-fill_done latency SHALL be 3 cycles (accept, REQ with ready=1, WAIT with resp_valid=1, WRITE).
REQ-024 kill_i in REQ: drop request same cycle if no handshake that cycle, go IDLE; if handshake coincides, go DRAIN.
REQ-025 kill_i in WAIT without resp_valid: go DRAIN; with resp_valid same cycle: discard, go IDLE.
REQ-026 DRAIN: wait for ifill_resp_valid_i, discard, no writes, no fill_done_o, go IDLE.
REQ-027 kill_i in WRITE or IDLE SHALL be ignored; miss_i and kill_i together in IDLE: miss ignored.
REQ-028 All write enables SHALL be zero outside WRITE; at most one bit set in each.

Reset
REQ-029 rst_i SHALL force IDLE, pointer 0, all latches 0, miss_ready_o=1 (combinational from IDLE), all other outputs 0, regardless of state; in-flight L2 responses after reset SHALL be ignored.

Structure
REQ-030 State enum, victim pointer width and paddr composition SHALL live in sargantana_icache_pkg.
REQ-031 First-invalid selection SHALL instantiate existing sargantana_icache_tzc_idx on ~way_valid_bits_i; no other sub-module.

Verification
REQ-032 N_WAY=4, valid=4'b0101, miss idx=5 tag=0x1A, ready=1, resp 1 cycle later -> tag_we_o=4'b0010, wr_idx_o=5, fill_done_o at cycle 3.
REQ-033 Four consecutive misses with valid=4'b1111 -> victims 0,1,2,3 then 0 (wrap).
REQ-034 ifill_req_ready_i low 5 cycles -> req_valid_o and paddr held constant, no write.
REQ-035 kill_i 2 cycles into WAIT, resp 4 cycles later -> DRAIN, zero write enables, no fill_done_o, miss_ready_o after resp.
REQ-036 rst_i asserted mid-WAIT -> outputs zero asynchronously, IDLE, late resp_valid produces no write.
